ka_gf2m_mult_pipe: RTL and testbench
====================================

Name: ka_gf2m_mult_pipe

Overview:
- Pipelined, parametrised one-level Karatsuba multiplier over GF(2)[x]; successor to the fixed-width combinational Karatsuba multipliers.
- Adds a valid/ready handshake, 3-stage registered datapath with per-stage backpressure, and an optional per-transaction reduction modulo the field polynomial.
- Sits between the operand source (field-arithmetic sequencer) and the result consumer in the binary-field multiplier chain.

Parameters:
- WIDTH, 6, operand width m; must be even and >= 2, so the half width is H = WIDTH/2.
- POLY, 6'b000011, low WIDTH coefficients of the field polynomial P(x) = x^WIDTH + POLY. The default is x^6+x+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept an operand transaction this cycle.
- in_a  in  WIDTH  operand a; bit i is the coefficient of x^i.
- in_b  in  WIDTH  operand b.
- in_reduce  in  1  1 = return the product mod P(x); 0 = return the raw product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  2*WIDTH-1  result.
- out_reduced  out  1  copy of in_reduce for this result.

Behaviour:
- Handshake rules:
  - Input transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - in_valid and operands may change freely while in_ready is low.
  - out_y and out_reduced hold stable while out_valid && !out_ready.
- Stage 1 (S1), registered on input transfer. Three half products, each 2H-1 bits, carry-less:
  - L = a[H-1:0]*b[H-1:0]
  - U = a[W-1:H]*b[W-1:H]
  - M = (a_lo^a_hi)*(b_lo^b_hi)
  - S1 also registers the reduce flag.
- Stage 2 (S2), overlap recombination: P = L ^ ((L^U^M) << H) ^ (U << W), truncated to 2W-1 bits. Registers P and the flag.
- Stage 3 (S3, the output register):
  - flag=0: out_y = P.
  - flag=1: out_y = P mod P(x). Fold from bit 2W-2 down to bit W: a set bit k is cleared and POLY<<(k-W) is XORed in. The result occupies bits [W-1:0]; bits [2W-2:W] are zero.
  - Combinational within S3; no extra cycle.
- Latency: 3 cycles from input transfer to out_valid when not stalled. Throughput is 1 transaction per cycle.
- Backpressure:
  - Each stage has a valid bit v1..v3. Stage k loads when !vk or stage k+1 loads this cycle. S3 "loads next" when out_ready is high.
  - in_ready = !v1 || S2 loads. This may be combinational from out_ready through the chain.
  - Bubbles collapse; capacity is 3 transactions.
  - A stage that is not loaded and not drained holds its contents.
- Ordering: results leave strictly in acceptance order; no drop, no duplication.
- Simultaneous events: when S3 drains and S2 refills it in the same cycle, out_valid stays high and the new data appears the next cycle.
- Reset (async assert, sync-safe release):
  - v1..v3 = 0 and all data registers = 0.
  - out_valid=0, out_y=0, out_reduced=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight transactions and produces no partial output.
- Zero operands give a zero product in both modes. The reduced result is always deg < WIDTH.

Test Plan (W=6, POLY=6'b000011):
- Raw mode: a=6'h3F, b=6'h3F, reduce=0, out_ready=1 -> out_valid exactly 3 cycles after accept, out_y=11'h555, out_reduced=0.
- Reduce mode:
  - a=6'h20, b=6'h02, reduce=1 -> out_y=11'h003.
  - a=6'h3F, b=6'h3F, reduce=1 -> out_y=11'h02A.
  - a=6'h01, b=6'h2B -> out_y=11'h02B in both modes.
- Streaming: 16 random back-to-back transactions with alternating reduce and out_ready=1 -> one result per cycle, in order, matching the software carry-less model. in_ready stays 1 throughout.
- Backpressure:
  - Drive continuous in_valid with out_ready=0 for 6 cycles -> exactly 3 accepted; in_ready=0 afterwards; out_y stable while stalled.
  - Then out_ready=1 -> the 3 results drain in order, followed by the next inputs with no gap.
- Bubble collapse: accept 1 transaction, hold out_ready=0 until out_valid, then drive 2 more -> both accepted immediately (v1/v2 free) and queued behind the held result.
- Reset mid-operation: assert rst_n=0 with 3 in flight -> out_valid=0 and out_y=0 immediately (async). After release, in_ready=1, and a new a=6'h20, b=6'h02, reduce=0 returns out_y=11'h040 with 3-cycle latency.

Source files
------------

// File: rtl/ka_gf2m_mult_pipe.sv
// Three-stage one-level Karatsuba multiplier over GF(2)[x] with valid/ready
// flow control and optional reduction modulo x^WIDTH + POLY.
module ka_gf2m_mult_pipe #(
  parameter int                 WIDTH = 6,
  parameter logic [WIDTH-1:0]   POLY  = 6'b000011
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_reduce,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-2:0]   out_y,
  output logic                 out_reduced
);

  localparam int H  = WIDTH / 2;
  localparam int HW = 2 * H - 1;
  localparam int PW = 2 * WIDTH - 1;

  function automatic logic [HW-1:0] clmul_half(input logic [H-1:0] x,
                                               input logic [H-1:0] y);
    logic [HW-1:0] acc;
    acc = '0;
    for (int i = 0; i < H; i++)
      if (y[i]) acc ^= HW'(x) << i;
    return acc;
  endfunction

  function automatic logic [PW-1:0] recombine(input logic [HW-1:0] l,
                                              input logic [HW-1:0] u,
                                              input logic [HW-1:0] m);
    return PW'(l) ^ (PW'(l ^ u ^ m) << H) ^ (PW'(u) << WIDTH);
  endfunction

  // Each set bit x^k (k >= WIDTH) is replaced by POLY * x^(k-WIDTH), top-down.
  function automatic logic [PW-1:0] reduce_mod(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = p;
    for (int k = PW - 1; k >= WIDTH; k--)
      if (r[k]) begin
        r[k] = 1'b0;
        r[k-WIDTH +: WIDTH] ^= POLY;
      end
    return r;
  endfunction

  logic          vld_p0, vld_p1, vld_p2;
  logic          en_p0, en_p1, en_p2;
  logic [HW-1:0] l_p0, u_p0, m_p0;
  logic          red_p0, red_p1, red_p2;
  logic [PW-1:0] prod_p1, y_p2;
  logic [H-1:0]  a_mid, b_mid;

  assign en_p2    = !vld_p2 || out_ready;
  assign en_p1    = !vld_p1 || en_p2;
  assign en_p0    = !vld_p0 || en_p1;
  assign in_ready = en_p0;

  assign a_mid = in_a[H-1:0] ^ in_a[WIDTH-1:H];
  assign b_mid = in_b[H-1:0] ^ in_b[WIDTH-1:H];

  // Stage 1: three half-width carry-less products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      l_p0   <= '0;
      u_p0   <= '0;
      m_p0   <= '0;
      red_p0 <= 1'b0;
    end else if (en_p0) begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        l_p0   <= clmul_half(in_a[H-1:0], in_b[H-1:0]);
        u_p0   <= clmul_half(in_a[WIDTH-1:H], in_b[WIDTH-1:H]);
        m_p0   <= clmul_half(a_mid, b_mid);
        red_p0 <= in_reduce;
      end
    end
  end

  // Stage 2: overlap recombination into the full product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      prod_p1 <= '0;
      red_p1  <= 1'b0;
    end else if (en_p1) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        prod_p1 <= recombine(l_p0, u_p0, m_p0);
        red_p1  <= red_p0;
      end
    end
  end

  // Stage 3: optional reduction, output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      y_p2   <= '0;
      red_p2 <= 1'b0;
    end else if (en_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        y_p2   <= red_p1 ? reduce_mod(prod_p1) : prod_p1;
        red_p2 <= red_p1;
      end
    end
  end

  assign out_valid   = vld_p2;
  assign out_y       = y_p2;
  assign out_reduced = red_p2;

endmodule

// File: tb/tb_ka_gf2m_mult_pipe.sv
// Directed-vector and scoreboard bench for ka_gf2m_mult_pipe (WIDTH=6, x^6+x+1).
module tb_ka_gf2m_mult_pipe;

  localparam int W = 6;
  localparam logic [W-1:0] P = 6'b000011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_reduce = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-2:0] out_y;
  logic          out_reduced;

  ka_gf2m_mult_pipe #(.WIDTH(W), .POLY(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_reduce(in_reduce),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_reduced(out_reduced)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           red;
    logic [2*W-2:0] y;
  } vec_t;

  vec_t vecs[8];

  int n_tests = 0;
  int n_fail  = 0;
  int n_in    = 0;
  int n_out   = 0;
  logic [2*W-2:0] exp_y_q[$];
  logic           exp_r_q[$];

  logic           obs_valid, obs_ready, obs_red;
  logic [2*W-2:0] obs_y;

  function automatic logic [2*W-2:0] clmul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-2:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      if (a[i]) r ^= (2*W-1)'(b) << i;
    return r;
  endfunction

  // Shift-and-add multiply in the field, reducing after every doubling.
  function automatic logic [2*W-2:0] modmul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      r = r << 1;
      if (r[W]) r = {1'b0, r[W-1:0] ^ P};
      if (b[i]) r[W-1:0] = r[W-1:0] ^ a;
    end
    return (2*W-1)'(r[W-1:0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with inputs set; samples, scores, advances one cycle.
  task automatic tick();
    logic [2*W-2:0] ey;
    logic           er;
    #1;
    obs_valid = out_valid;
    obs_ready = in_ready;
    obs_y     = out_y;
    obs_red   = out_reduced;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_y_q.size() == 0) check("unexpected_output", 32'(out_valid), 32'd0);
      else begin
        ey = exp_y_q.pop_front();
        er = exp_r_q.pop_front();
        check("sb_y", 32'(out_y), 32'(ey));
        check("sb_reduced", 32'(out_reduced), 32'(er));
      end
    end
    if (in_valid && in_ready) begin
      n_in++;
      exp_y_q.push_back(in_reduce ? modmul_ref(in_a, in_b) : clmul_ref(in_a, in_b));
      exp_r_q.push_back(in_reduce);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_y_q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(exp_y_q.size()), 32'd0);
  endtask

  task automatic run_latency(input vec_t v, input string tag);
    int n;
    in_a = v.a; in_b = v.b; in_reduce = v.red;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check({tag, "_accept"}, 32'(obs_ready), 32'd1);
    in_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!obs_valid && n < 10);
    check({tag, "_latency"}, 32'(n), 32'd3);
    check({tag, "_y"}, 32'(obs_y), 32'(v.y));
    check({tag, "_reduced"}, 32'(obs_red), 32'(v.red));
  endtask

  initial begin
    int base_in, base_out, n;
    logic [2*W-2:0] held_y;
    logic           have_held;

    vecs[0] = '{a: 6'h3F, b: 6'h3F, red: 1'b0, y: 11'h555};
    vecs[1] = '{a: 6'h20, b: 6'h02, red: 1'b1, y: 11'h003};
    vecs[2] = '{a: 6'h3F, b: 6'h3F, red: 1'b1, y: 11'h02A};
    vecs[3] = '{a: 6'h01, b: 6'h2B, red: 1'b0, y: 11'h02B};
    vecs[4] = '{a: 6'h01, b: 6'h2B, red: 1'b1, y: 11'h02B};
    vecs[5] = '{a: 6'h00, b: 6'h00, red: 1'b0, y: 11'h000};
    vecs[6] = '{a: 6'h00, b: 6'h3F, red: 1'b1, y: 11'h000};
    vecs[7] = '{a: 6'h20, b: 6'h02, red: 1'b0, y: 11'h040};

    #2 rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_out_reduced", 32'(out_reduced), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(obs_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_latency(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back stream, alternating reduce
    base_out = n_out;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_a = W'($urandom); in_b = W'($urandom); in_reduce = i[0];
      tick();
      check("stream_in_ready", 32'(obs_ready), 32'd1);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("stream_throughput", 32'(n_out - base_out), 32'd16);
    drain();

    // Stall with continuous input: capacity 3, output held
    base_in = n_in; have_held = 1'b0; held_y = '0;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_a = W'($urandom); in_b = W'($urandom); in_reduce = $urandom_range(0, 1);
      tick();
      if (obs_valid && have_held) check("stall_y_stable", 32'(obs_y), 32'(held_y));
      if (obs_valid) begin held_y = obs_y; have_held = 1'b1; end
    end
    check("stall_accepted", 32'(n_in - base_in), 32'd3);
    check("stall_in_ready", 32'(obs_ready), 32'd0);
    check("stall_out_valid", 32'(obs_valid), 32'd1);
    base_out = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_a = W'($urandom); in_b = W'($urandom); in_reduce = $urandom_range(0, 1);
      tick();
    end
    check("release_no_gap", 32'(n_out - base_out), 32'd6);
    drain();

    // Bubble collapse behind a held result
    out_ready = 1'b0;
    in_a = 6'h15; in_b = 6'h2A; in_reduce = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!obs_valid && n < 10);
    check("bubble_first_valid", 32'(obs_valid), 32'd1);
    held_y = obs_y;
    in_a = 6'h07; in_b = 6'h39; in_reduce = 1'b0; in_valid = 1'b1;
    tick();
    check("bubble_accept1", 32'(obs_ready), 32'd1);
    in_a = 6'h33; in_b = 6'h0C; in_reduce = 1'b1;
    tick();
    check("bubble_accept2", 32'(obs_ready), 32'd1);
    in_a = 6'h01; in_b = 6'h01; in_reduce = 1'b0;
    tick();
    check("bubble_full", 32'(obs_ready), 32'd0);
    check("bubble_y_stable", 32'(obs_y), 32'(held_y));
    drain();

    // Reset with three transactions in flight
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_a = W'($urandom) | 6'h01; in_b = W'($urandom) | 6'h01; in_reduce = 1'b0;
      tick();
    end
    check("pre_reset_valid", 32'(obs_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_y", 32'(out_y), 32'd0);
    check("midrst_out_reduced", 32'(out_reduced), 32'd0);
    exp_y_q.delete();
    exp_r_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("postrst_in_ready", 32'(obs_ready), 32'd1);
    check("postrst_out_valid", 32'(obs_valid), 32'd0);
    run_latency(vecs[7], "postrst");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
